qdrc_wr_buf: RTL



---
 rtl/qdrc_wr_buf.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/qdrc_wr_buf.sv
`default_nettype none
// ============================================================================
// Module      : qdrc_wr_buf
// Description : Buffered QDR write path. User write requests (address,
//               dual-edge data, byte enables) are queued in a FIFO and issued
//               to the PHY only in arbiter-granted write slots. Data and byte
//               enables are delayed by DATA_LATENCY cycles relative to the
//               write command to meet the QDR late-write timing.
// Options     : `define QDRC_WR_BEN_ACTIVE_LOW_EN to drive phy_ben as active-low
//               (QDR BW_n); idle/reset value then becomes all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module qdrc_wr_buf #(
  parameter int DATA_WIDTH   = 36,
  parameter int BW_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 21,
  parameter int FIFO_AW      = 4,
  parameter int DATA_LATENCY = 1   // legal range 0..3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      usr_strb,
  input  logic [ADDR_WIDTH-1:0]     usr_addr,
  input  logic [2*DATA_WIDTH-1:0]   usr_data,
  input  logic [2*BW_WIDTH-1:0]     usr_ben,
  output logic                      usr_rdy,
  input  logic                      phy_wr_en,
  output logic                      phy_strb,
  output logic [ADDR_WIDTH-1:0]     phy_addr,
  output logic [2*DATA_WIDTH-1:0]   phy_data,
  output logic [2*BW_WIDTH-1:0]     phy_ben,
  output logic [FIFO_AW:0]          fifo_level,
  output logic                      wr_ovf
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW2   = 2 * DATA_WIDTH;
  localparam int BW2   = 2 * BW_WIDTH;
  localparam int EW    = ADDR_WIDTH + DW2 + BW2;

  localparam logic [FIFO_AW:0]   LEVEL_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LEVEL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW-1){1'b0}}, 1'b1};

`ifdef QDRC_WR_BEN_ACTIVE_LOW_EN
  localparam logic [BW2-1:0] BEN_DISABLE = {BW2{1'b1}};
`else
  localparam logic [BW2-1:0] BEN_DISABLE = {BW2{1'b0}};
`endif

  // FIFO storage and bookkeeping
  logic [EW-1:0]         r_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0]    r_wr_ptr;
  logic [FIFO_AW-1:0]    r_rd_ptr;
  logic [FIFO_AW:0]      r_level;
  logic                  r_live;     // low only until the first edge after reset
  logic                  r_ovf;

  // Command stage and data/ben pipeline (stage 0 is registered with phy_strb)
  logic                  r_strb;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_pv [0:DATA_LATENCY];
  logic [DW2-1:0]        r_pd [0:DATA_LATENCY];
  logic [BW2-1:0]        r_pb [0:DATA_LATENCY];

  logic                  w_full;
  logic                  w_rdy;
  logic                  w_push;
  logic                  w_pop;
  logic [EW-1:0]         w_head;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DW2-1:0]        w_head_data;
  logic [BW2-1:0]        w_head_ben;

  // Ready depends on registered state only; a pop on the same edge never
  // makes room for a request presented while full.
  assign w_full = (r_level == LEVEL_FULL);
  assign w_rdy  = r_live & ~w_full;
  assign w_push = usr_strb & w_rdy;
  assign w_pop  = phy_wr_en & (r_level != '0);

  assign w_head = r_mem[r_rd_ptr];
  assign {w_head_addr, w_head_data, w_head_ben} = w_head;

  // FIFO entry write; storage needs no reset since level gates all reads
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= {usr_addr, usr_data, usr_ben};
    end
  end

  // Pointers, occupancy counter and post-reset ready qualifier
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LEVEL_ONE;
        2'b01:   r_level <= r_level - LEVEL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow: any request seen while full is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (usr_strb && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  // Issue stage plus late-write data pipeline; idle stages keep their data
  // but carry valid=0 so the output byte enables go to disable
  always_ff @(posedge clk) begin
    if (reset) begin
      r_strb <= 1'b0;
      r_addr <= '0;
      for (int i = 0; i <= DATA_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      r_strb  <= w_pop;
      r_pv[0] <= w_pop;
      if (w_pop) begin
        r_addr  <= w_head_addr;
        r_pd[0] <= w_head_data;
        r_pb[0] <= w_head_ben;
      end
      for (int i = 1; i <= DATA_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_pd[i] <= r_pd[i-1];
          r_pb[i] <= r_pb[i-1];
        end
      end
    end
  end

  assign usr_rdy    = w_rdy;
  assign fifo_level = r_level;
  assign wr_ovf     = r_ovf;
  assign phy_strb   = r_strb;
  assign phy_addr   = r_addr;
  assign phy_data   = r_pd[DATA_LATENCY];

`ifdef QDRC_WR_BEN_ACTIVE_LOW_EN
  assign phy_ben = r_pv[DATA_LATENCY] ? ~r_pb[DATA_LATENCY] : BEN_DISABLE;
`else
  assign phy_ben = r_pv[DATA_LATENCY] ? r_pb[DATA_LATENCY] : BEN_DISABLE;
`endif

endmodule
`default_nettype wire
